// File: rtl/unit_prop_scheduler.sv
// Unit-propagation scheduler: issues pending unit variables lowest-index first, merges new units, aborts on conflict.
// Latency: start -> first issue_valid 2 cycles; accept -> next issue_valid 2 cycles; empty run start -> done 2 cycles.
// Backpressure: issue_valid/issue_var held stable until issue_ready; nothing is cleared from pending before acceptance.
module unit_prop_scheduler #(
  parameter int W    = 8,
  parameter int IDXW = $clog2(W)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_en,
  input  logic [W-1:0]    load_vec,
  input  logic            start,
  input  logic            add_en,
  input  logic [W-1:0]    add_vec,
  input  logic            conflict,
  output logic            issue_valid,
  output logic [IDXW-1:0] issue_var,
  input  logic            issue_ready,
  output logic            busy,
  output logic            done,
  output logic            aborted,
  output logic [W-1:0]    pending,
  output logic [IDXW:0]   issued_cnt
);

  typedef enum logic [1:0] {IDLE, SCAN, ISSUE, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    pending_q, pending_d;
  logic [IDXW-1:0] var_q, var_d;
  logic [IDXW:0]   cnt_q, cnt_d;
  logic            aborted_q, aborted_d;
  logic [IDXW-1:0] low_idx;
  logic            run_st;
  logic            accept;

  assign run_st = (state_q == SCAN) || (state_q == ISSUE);
  assign accept = (state_q == ISSUE) && issue_ready;

  // Pending bitmap next value: load (idle only), clear-on-accept, then merge adds; conflict wipes everything.
  always_comb begin
    pending_d = pending_q;
    if (!run_st && load_en) begin
      pending_d = load_vec;
    end
    if (accept && !conflict) begin
      pending_d[var_q] = 1'b0;
    end
    if (add_en) begin
      pending_d = pending_d | add_vec;
    end
    if (run_st && conflict) begin
      pending_d = '0;
    end
  end

  // Priority encoder: lowest set index of the updated bitmap, so same-cycle adds are visible to SCAN.
  always_comb begin
    low_idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (pending_d[i]) begin
        low_idx = IDXW'(i);
      end
    end
  end

  // Next-state and run bookkeeping (issued count, abort flag, latched issue variable).
  always_comb begin
    state_d   = state_q;
    var_d     = var_q;
    cnt_d     = cnt_q;
    aborted_d = aborted_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SCAN;
          cnt_d     = '0;
          aborted_d = 1'b0;
        end
      end
      SCAN: begin
        if (conflict) begin
          state_d   = DONE;
          aborted_d = 1'b1;
        end else if (pending_d == '0) begin
          state_d = DONE;
        end else begin
          var_d   = low_idx;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (conflict) begin
          state_d   = DONE;
          aborted_d = 1'b1;
        end else if (issue_ready) begin
          cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + (IDXW+1)'(1);
          state_d = SCAN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      var_q     <= '0;
      cnt_q     <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      var_q     <= var_d;
      cnt_q     <= cnt_d;
      aborted_q <= aborted_d;
    end
  end

  assign issue_valid = (state_q == ISSUE);
  assign issue_var   = var_q;
  assign busy        = run_st;
  assign done        = (state_q == DONE);
  assign aborted     = aborted_q;
  assign pending     = pending_q;
  assign issued_cnt  = cnt_q;

endmodule

// File: tb/tb_unit_prop_scheduler.sv
// Directed bench for unit_prop_scheduler: ordered issue, backpressure, merge, conflict, empty run, reset.
// Latency: checks are taken 1 time unit after each rising edge.
// Backpressure: issue_ready driven directly by the stimulus sequence.
module tb_unit_prop_scheduler;

  logic       clk;
  logic       rst_n;
  logic       load_en;
  logic [7:0] load_vec;
  logic       start;
  logic       add_en;
  logic [7:0] add_vec;
  logic       conflict;
  logic       issue_valid;
  logic [2:0] issue_var;
  logic       issue_ready;
  logic       busy;
  logic       done;
  logic       aborted;
  logic [7:0] pending;
  logic [3:0] issued_cnt;

  int n_cmp = 0;
  int n_err = 0;

  unit_prop_scheduler #(.W(8), .IDXW(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_en    (load_en),
    .load_vec   (load_vec),
    .start      (start),
    .add_en     (add_en),
    .add_vec    (add_vec),
    .conflict   (conflict),
    .issue_valid(issue_valid),
    .issue_var  (issue_var),
    .issue_ready(issue_ready),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .pending    (pending),
    .issued_cnt (issued_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load a bitmap and start in the same cycle; returns two edges later (ISSUE for a non-empty run).
  task automatic go(input logic [7:0] v);
    load_en  = 1'b1;
    load_vec = v;
    start    = 1'b1;
    step();
    load_en  = 1'b0;
    start    = 1'b0;
    step();
  endtask

  initial begin
    int exp_vars[6];
    exp_vars = '{0, 1, 3, 4, 5, 7};
    rst_n = 1'b0; load_en = 1'b0; load_vec = '0; start = 1'b0;
    add_en = 1'b0; add_vec = '0; conflict = 1'b0; issue_ready = 1'b0;
    #12;
    chk("rst_valid",   32'(issue_valid), 32'd0);
    chk("rst_busy",    32'(busy),        32'd0);
    chk("rst_done",    32'(done),        32'd0);
    chk("rst_aborted", 32'(aborted),     32'd0);
    chk("rst_pending", 32'(pending),     32'd0);
    chk("rst_var",     32'(issue_var),   32'd0);
    chk("rst_cnt",     32'(issued_cnt),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: ordered issue with ready tied high, two cycles per issue
    issue_ready = 1'b1;
    load_en = 1'b1; load_vec = 8'hBB; start = 1'b1;
    step();
    load_en = 1'b0; start = 1'b0;
    chk("t1_scan_busy",  32'(busy),        32'd1);
    chk("t1_scan_valid", 32'(issue_valid), 32'd0);
    chk("t1_scan_pend",  32'(pending),     32'hBB);
    step();
    for (int i = 0; i < 6; i++) begin
      chk("t1_valid", 32'(issue_valid), 32'd1);
      chk("t1_var",   32'(issue_var),   32'(exp_vars[i]));
      step();
      chk("t1_gap", 32'(issue_valid), 32'd0);
      step();
    end
    chk("t1_done",    32'(done),       32'd1);
    chk("t1_cnt",     32'(issued_cnt), 32'd6);
    chk("t1_pending", 32'(pending),    32'd0);
    chk("t1_aborted", 32'(aborted),    32'd0);
    chk("t1_busy",    32'(busy),       32'd0);
    step();
    chk("t1_done_1cyc", 32'(done), 32'd0);

    // 2: backpressure holds the first issue stable
    issue_ready = 1'b0;
    go(8'hBB);
    for (int k = 0; k < 3; k++) begin
      chk("t2_hold_valid", 32'(issue_valid), 32'd1);
      chk("t2_hold_var",   32'(issue_var),   32'd0);
      chk("t2_hold_pend",  32'(pending),     32'hBB);
      step();
    end
    issue_ready = 1'b1;
    step();
    chk("t2_cleared", 32'(pending), 32'hBA);
    for (int k = 0; k < 40 && !done; k++) step();
    chk("t2_done", 32'(done),       32'd1);
    chk("t2_cnt",  32'(issued_cnt), 32'd6);
    step();

    // 3: units merged in the accept cycle of var 1
    go(8'h02);
    chk("t3_var1", 32'(issue_var), 32'd1);
    add_en = 1'b1; add_vec = 8'h44;
    step();
    add_en = 1'b0; add_vec = '0;
    chk("t3_pend", 32'(pending), 32'h44);
    step();
    chk("t3_var2", 32'(issue_var), 32'd2);
    step(); step();
    chk("t3_var6", 32'(issue_var), 32'd6);
    step(); step();
    chk("t3_done", 32'(done),       32'd1);
    chk("t3_cnt",  32'(issued_cnt), 32'd3);
    step();

    // 4: conflict beats a same-cycle accept of var 2
    go(8'hFF);
    step(); step(); step(); step();
    chk("t4_var2", 32'(issue_var), 32'd2);
    conflict = 1'b1; add_en = 1'b1; add_vec = 8'h80;
    step();
    conflict = 1'b0; add_en = 1'b0; add_vec = '0;
    chk("t4_done",    32'(done),       32'd1);
    chk("t4_aborted", 32'(aborted),    32'd1);
    chk("t4_pending", 32'(pending),    32'd0);
    chk("t4_cnt",     32'(issued_cnt), 32'd2);
    step();
    chk("t4_sticky", 32'(aborted), 32'd1);

    // 5: empty run, start/load while busy ignored
    load_en = 1'b1; load_vec = 8'h00; start = 1'b1;
    step();
    chk("t5_abort_clr", 32'(aborted),     32'd0);
    chk("t5_busy",      32'(busy),        32'd1);
    chk("t5_valid",     32'(issue_valid), 32'd0);
    load_vec = 8'hFF;
    step();
    load_en = 1'b0; start = 1'b0;
    chk("t5_done",    32'(done),        32'd1);
    chk("t5_valid2",  32'(issue_valid), 32'd0);
    chk("t5_pending", 32'(pending),     32'd0);
    chk("t5_cnt",     32'(issued_cnt),  32'd0);
    step();
    chk("t5_idle", 32'(busy), 32'd0);
    chk("t5_nodone", 32'(done), 32'd0);

    // add in IDLE accumulates for the next run
    add_en = 1'b1; add_vec = 8'h10;
    step();
    add_en = 1'b0; add_vec = '0;
    chk("idle_add", 32'(pending), 32'h10);

    // 6: reset in the middle of ISSUE
    issue_ready = 1'b0;
    go(8'h0C);
    chk("t6_var", 32'(issue_var), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", 32'(issue_valid), 32'd0);
    chk("t6_busy",  32'(busy),        32'd0);
    chk("t6_pend",  32'(pending),     32'd0);
    chk("t6_var0",  32'(issue_var),   32'd0);
    step();
    chk("t6_nodone", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("t6_idle_busy", 32'(busy),    32'd0);
    chk("t6_idle_pend", 32'(pending), 32'd0);
    chk("t6_idle_done", 32'(done),    32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
